vertex_post_processor_rcp: RTL and testbench

// - Parametrised successor vertex post-processor; sits between vertex shader and rasteriser setup.
// - Full 6-plane frustum test on clip-space vertex. One shared reciprocal 1/w, then three multiplies.
// - Viewport transform to pixel coordinates plus unsigned depth. Valid/ready on both sides, tag passthrough.

---
 rtl/vpp_pkg.sv | 13 +
 rtl/fixed_point_divide.sv | 70 +++++++
 rtl/vertex_post_processor_rcp.sv | 145 ++++++++++++++
 tb/tb_vertex_post_processor_rcp.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/vpp_pkg.sv
// vpp_pkg: shared state encoding and clip-flag layout for the vertex post-processor.
package vpp_pkg;
   typedef enum logic [2:0] {IDLE, CLIP, RECIP, SCALE, EMIT} vpp_rcp_state_t;
   localparam int CLIP_FLAG_XLO  = 0;
   localparam int CLIP_FLAG_XHI  = 1;
   localparam int CLIP_FLAG_YLO  = 2;
   localparam int CLIP_FLAG_YHI  = 3;
   localparam int CLIP_FLAG_ZNR  = 4;
   localparam int CLIP_FLAG_ZFR  = 5;
   localparam int CLIP_FLAG_WBAD = 6;
   localparam int CLIP_FLAG_W    = 7;
   typedef logic [CLIP_FLAG_W-1:0] clip_flags_t;
endpackage

// File: rtl/fixed_point_divide.sv
// fixed_point_divide: signed q = (a << FRACBITS) / b, restoring, one quotient bit per cycle.
// o_done pulses WIDTH+FRACBITS cycles after i_start is sampled; o_q/o_valid/o_ovf hold until the next start.
module fixed_point_divide #(
   parameter int WIDTH    = 24,
   parameter int FRACBITS = 13
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    i_start,
   input  logic signed [WIDTH-1:0] i_a,
   input  logic signed [WIDTH-1:0] i_b,
   output logic                    o_done,
   output logic                    o_valid,
   output logic                    o_ovf,
   output logic signed [WIDTH-1:0] o_q
);
   localparam int N  = WIDTH + FRACBITS;
   localparam int CW = $clog2(N + 1);
   localparam logic [N-1:0] QMAX = N'(2 ** (WIDTH - 1) - 1);
   logic [N-1:0]     r_dvd;
   logic [WIDTH-1:0] r_rem, r_bmag;
   logic [CW-1:0]    r_cnt;
   logic             r_neg, r_bzero;
   logic [WIDTH-1:0] w_amag, w_bmag;
   logic [WIDTH:0]   w_sh;
   logic             w_ge, w_ovf;
   logic [N-1:0]     w_qn;
   always_comb begin
      w_amag = i_a[WIDTH-1] ? -i_a : i_a;
      w_bmag = i_b[WIDTH-1] ? -i_b : i_b;
      w_sh   = {r_rem, r_dvd[N-1]};
      w_ge   = w_sh >= {1'b0, r_bmag};
      w_qn   = {r_dvd[N-2:0], w_ge};
      w_ovf  = r_neg ? (w_qn > QMAX + N'(1)) : (w_qn > QMAX);
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_dvd   <= '0;
         r_rem   <= '0;
         r_bmag  <= '0;
         r_cnt   <= '0;
         r_neg   <= 1'b0;
         r_bzero <= 1'b0;
         o_done  <= 1'b0;
         o_valid <= 1'b0;
         o_ovf   <= 1'b0;
         o_q     <= '0;
      end else begin
         o_done <= 1'b0;
         if (i_start) begin
            r_dvd   <= {w_amag, FRACBITS'(0)};
            r_rem   <= '0;
            r_bmag  <= w_bmag;
            r_neg   <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
            r_bzero <= i_b == '0;
            r_cnt   <= CW'(N);
         end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            r_dvd <= w_qn;
            r_rem <= w_ge ? WIDTH'(w_sh - {1'b0, r_bmag}) : w_sh[WIDTH-1:0];
            if (r_cnt == CW'(1)) begin
               o_done  <= 1'b1;
               o_valid <= !r_bzero;
               o_ovf   <= w_ovf;
               o_q     <= r_neg ? -w_qn[WIDTH-1:0] : w_qn[WIDTH-1:0];
            end
         end
      end
   end
endmodule

// File: rtl/vertex_post_processor_rcp.sv
// vertex_post_processor_rcp: frustum clip, shared 1/w reciprocal and viewport transform of one
// clip-space vertex at a time; culled vertices are still emitted so the tag stream stays ordered.
module vertex_post_processor_rcp
   import vpp_pkg::*;
#(
   parameter int IV_DATAWIDTH = 24,
   parameter int IV_FRACBITS  = 13,
   parameter int OV_DATAWIDTH = 12,
   parameter int O_DEPTH_BITS = 16,
   parameter int TAG_W        = 8,
   parameter int WIDTH        = 320,
   parameter int HEIGHT       = 320
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic signed [IV_DATAWIDTH-1:0] i_vertex [4],
   input  logic        [TAG_W-1:0]        i_tag,
   input  logic                           i_valid,
   output logic                           i_ready,
   output logic signed [OV_DATAWIDTH-1:0] o_pixel [2],
   output logic        [O_DEPTH_BITS-1:0] o_depth,
   output logic        [TAG_W-1:0]        o_tag,
   output logic        [CLIP_FLAG_W-1:0]  o_clip_flags,
   output logic                           o_culled,
   output logic                           o_valid,
   input  logic                           o_ready
);
   localparam int D = IV_DATAWIDTH;
   localparam int F = IV_FRACBITS;
   localparam int P = 2 * D;
   localparam int Q = P + 16;
   localparam logic signed [D-1:0] ONE_D = D'(1 << F);
   localparam logic signed [P-1:0] ONE_P = P'(1 << F);
   localparam logic signed [Q-1:0] ONE_Q = Q'(1 << F);
   localparam logic signed [Q-1:0] W_Q   = Q'(WIDTH);
   localparam logic signed [Q-1:0] H_Q   = Q'(HEIGHT);
   localparam logic signed [Q-1:0] PMAX  = Q'(2 ** (OV_DATAWIDTH - 1) - 1);
   localparam logic signed [Q-1:0] PMIN  = Q'(-(2 ** (OV_DATAWIDTH - 1)));

   vpp_rcp_state_t         r_state;
   logic                   r_ready;
   logic signed [D-1:0]    r_v [4];
   logic [TAG_W-1:0]       r_tag;
   logic signed [D:0]      w_x, w_y, w_z, w_w, w_nw;
   clip_flags_t            w_flags, w_eflags;
   logic                   w_start, w_div_done, w_div_valid, w_div_ovf, w_bad, w_emit;
   logic signed [D-1:0]    w_q;
   logic signed [P-1:0]    w_ndc [3];
   logic signed [Q-1:0]    w_sx, w_sy;
   logic signed [OV_DATAWIDTH-1:0] w_px, w_py;
   logic [O_DEPTH_BITS-1:0] w_depth;

   assign i_ready = r_ready;

   // one extra bit so -w never overflows at the most negative w
   always_comb begin
      w_x  = (D + 1)'(r_v[0]);
      w_y  = (D + 1)'(r_v[1]);
      w_z  = (D + 1)'(r_v[2]);
      w_w  = (D + 1)'(r_v[3]);
      w_nw = -w_w;
      w_flags = '0;
      w_flags[CLIP_FLAG_XLO]  = w_x < w_nw;
      w_flags[CLIP_FLAG_XHI]  = w_x > w_w;
      w_flags[CLIP_FLAG_YLO]  = w_y < w_nw;
      w_flags[CLIP_FLAG_YHI]  = w_y > w_w;
      w_flags[CLIP_FLAG_ZNR]  = w_z <= 0;
      w_flags[CLIP_FLAG_ZFR]  = w_z >= w_w;
      w_flags[CLIP_FLAG_WBAD] = w_w <= 0;
   end

   fixed_point_divide #(.WIDTH(D), .FRACBITS(F)) u_rcp (
      .clk     (clk),
      .rstn    (rstn),
      .i_start (w_start),
      .i_a     (ONE_D),
      .i_b     (r_v[3]),
      .o_done  (w_div_done),
      .o_valid (w_div_valid),
      .o_ovf   (w_div_ovf),
      .o_q     (w_q)
   );

   // depth keeps the top O_DEPTH_BITS of the ndc_z fraction, zero-padded below
   always_comb begin
      for (int c = 0; c < 3; c++) w_ndc[c] = (P'(r_v[c]) * P'(w_q)) >>> F;
      w_sx    = ((Q'(w_ndc[0]) + ONE_Q) * W_Q) >>> (F + 1);
      w_sy    = ((ONE_Q - Q'(w_ndc[1])) * H_Q) >>> (F + 1);
      w_px    = w_sx > PMAX ? PMAX[OV_DATAWIDTH-1:0] : w_sx < PMIN ? PMIN[OV_DATAWIDTH-1:0] : w_sx[OV_DATAWIDTH-1:0];
      w_py    = w_sy > PMAX ? PMAX[OV_DATAWIDTH-1:0] : w_sy < PMIN ? PMIN[OV_DATAWIDTH-1:0] : w_sy[OV_DATAWIDTH-1:0];
      w_depth = w_ndc[2] >= ONE_P ? '1 : O_DEPTH_BITS'({w_ndc[2][F-1:0], O_DEPTH_BITS'(0)} >> F);
   end

   // the divider samples its start on the CLIP->RECIP edge
   always_comb begin
      w_bad    = !w_div_valid || w_div_ovf;
      w_start  = r_state == CLIP && !(|w_flags);
      w_emit   = (r_state == CLIP && |w_flags) || (r_state == RECIP && w_div_done && w_bad) || r_state == SCALE;
      w_eflags = r_state == CLIP ? w_flags : r_state == RECIP ? clip_flags_t'(1 << CLIP_FLAG_WBAD) : '0;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state      <= IDLE;
         r_ready      <= 1'b0;
         r_v          <= '{default: '0};
         r_tag        <= '0;
         o_valid      <= 1'b0;
         o_pixel      <= '{default: '0};
         o_depth      <= '0;
         o_tag        <= '0;
         o_clip_flags <= '0;
         o_culled     <= 1'b0;
      end else begin
         case (r_state)
            IDLE:
               if (r_ready && i_valid) begin
                  r_v     <= i_vertex;
                  r_tag   <= i_tag;
                  r_ready <= 1'b0;
                  r_state <= CLIP;
               end else r_ready <= 1'b1;
            CLIP:  r_state <= |w_flags ? EMIT : RECIP;
            RECIP: if (w_div_done) r_state <= w_bad ? EMIT : SCALE;
            SCALE: r_state <= EMIT;
            EMIT:
               if (o_ready) begin
                  o_valid <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= IDLE;
               end
            default: r_state <= IDLE;
         endcase
         if (w_emit) begin
            o_valid      <= 1'b1;
            o_tag        <= r_tag;
            o_clip_flags <= w_eflags;
            o_culled     <= |w_eflags;
            o_pixel[0]   <= |w_eflags ? '0 : w_px;
            o_pixel[1]   <= |w_eflags ? '0 : w_py;
            o_depth      <= |w_eflags ? '0 : w_depth;
         end
      end
   end
endmodule

// File: tb/tb_vertex_post_processor_rcp.sv
// tb_vertex_post_processor_rcp: directed and random vertices against an arithmetic reference model.
module tb_vertex_post_processor_rcp;
   localparam int DIV_LAT = 37;
   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic signed [23:0] i_vertex [4];
   logic [7:0]         i_tag;
   logic               i_valid, i_ready;
   logic signed [11:0] o_pixel [2];
   logic [15:0]        o_depth;
   logic [7:0]         o_tag;
   logic [6:0]         o_clip_flags;
   logic               o_culled, o_valid, o_ready;
   int n_vec = 0, n_err = 0;

   typedef struct {
      logic [6:0] flags;
      longint     px, py, depth;
      int         lat;
   } exp_t;

   vertex_post_processor_rcp dut (
      .clk(clk), .rstn(rstn), .i_vertex(i_vertex), .i_tag(i_tag), .i_valid(i_valid),
      .i_ready(i_ready), .o_pixel(o_pixel), .o_depth(o_depth), .o_tag(o_tag),
      .o_clip_flags(o_clip_flags), .o_culled(o_culled), .o_valid(o_valid), .o_ready(o_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint sat(input longint v);
      return v > 2047 ? 2047 : (v < -2048 ? -2048 : v);
   endfunction

   // latency counts edges from acceptance: culled in clip 2, divider reject DIV_LAT+3, visible DIV_LAT+4
   function automatic exp_t model(input longint x, y, z, w);
      exp_t e;
      longint rcp, nx, ny, nz;
      e.flags = {w <= 0, z >= w, z <= 0, y > w, y < -w, x > w, x < -w};
      e.px = 0; e.py = 0; e.depth = 0; e.lat = 2;
      if (e.flags != 0) return e;
      rcp = (longint'(1) << 26) / w;
      if (rcp > 8388607) begin
         e.flags = 7'b1000000;
         e.lat = DIV_LAT + 3;
         return e;
      end
      nx = (x * rcp) >>> 13;
      ny = (y * rcp) >>> 13;
      nz = (z * rcp) >>> 13;
      e.px = sat(((nx + 8192) * 320) >>> 14);
      e.py = sat(((8192 - ny) * 320) >>> 14);
      e.depth = nz >= 8192 ? 65535 : (nz % 8192) * 8;
      e.lat = DIV_LAT + 4;
      return e;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input longint x, y, z, w, input logic [7:0] tag);
      i_vertex[0] = 24'(x);
      i_vertex[1] = 24'(y);
      i_vertex[2] = 24'(z);
      i_vertex[3] = 24'(w);
      i_tag = tag;
      i_valid = 1'b1;
   endtask

   task automatic wait_ready;
      int n = 0;
      while (!i_ready && n < 200) begin
         step;
         n++;
      end
      if (n == 200) chk("ready_timeout", 64'(i_ready), 64'd1);
   endtask

   // call at the first sample after the acceptance edge
   task automatic expect_out(input longint x, y, z, w, input logic [7:0] tag);
      exp_t e = model(x, y, z, w);
      int n = 1;
      while (!o_valid && n < 200) begin
         step;
         n++;
      end
      chk("latency", 64'(n), 64'(e.lat));
      chk("flags", 64'(o_clip_flags), 64'(e.flags));
      chk("culled", 64'(o_culled), 64'(|e.flags));
      chk("px", 64'(o_pixel[0]), e.px);
      chk("py", 64'(o_pixel[1]), e.py);
      chk("depth", 64'(o_depth), e.depth);
      chk("tag", 64'(o_tag), 64'(tag));
   endtask

   task automatic run_vertex(input longint x, y, z, w, input logic [7:0] tag);
      wait_ready;
      offer(x, y, z, w, tag);
      step;
      i_valid = 1'b0;
      expect_out(x, y, z, w, tag);
      step;
      chk("valid_drop", 64'(o_valid), 64'd0);
   endtask

   initial begin
      longint x, y, z, w, span;
      logic signed [11:0] hold_px;
      logic [15:0] hold_d;
      i_valid = 1'b0;
      i_tag = '0;
      o_ready = 1'b1;
      for (int i = 0; i < 4; i++) i_vertex[i] = '0;
      repeat (3) step;
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_ready", 64'(i_ready), 64'd0);
      chk("rst_tag", 64'(o_tag), 64'd0);
      chk("rst_flags", 64'(o_clip_flags), 64'd0);
      chk("rst_px", 64'(o_pixel[0]), 64'd0);
      rstn = 1'b1;
      step;
      chk("rel_ready", 64'(i_ready), 64'd1);

      run_vertex(0, 0, 4096, 8192, 8'h5A);
      run_vertex(8192, -8192, 4096, 8192, 8'h11);
      run_vertex(-8192, 8192, 8191, 8192, 8'h12);
      run_vertex(0, 0, -819, 8192, 8'h13);
      run_vertex(0, 0, 0, 0, 8'h14);
      run_vertex(100, -5, 30, -40, 8'h15);
      run_vertex(0, 0, 1, 2, 8'h16);
      run_vertex(8193, 0, 100, 8192, 8'h17);

      // backpressure: second vertex held on the input while the first is stalled in EMIT
      o_ready = 1'b0;
      wait_ready;
      offer(1000, -2000, 3000, 4000, 8'hA1);
      step;
      offer(-500, 700, 900, 2000, 8'hA2);
      expect_out(1000, -2000, 3000, 4000, 8'hA1);
      hold_px = o_pixel[0];
      hold_d = o_depth;
      for (int i = 0; i < 5; i++) begin
         step;
         chk("stall_valid", 64'(o_valid), 64'd1);
         chk("stall_ready", 64'(i_ready), 64'd0);
         chk("stall_tag", 64'(o_tag), 64'hA1);
         chk("stall_px", 64'(o_pixel[0]), 64'(hold_px));
         chk("stall_depth", 64'(o_depth), 64'(hold_d));
      end
      o_ready = 1'b1;
      step;
      chk("drain_valid", 64'(o_valid), 64'd0);
      chk("drain_ready", 64'(i_ready), 64'd1);
      step;
      i_valid = 1'b0;
      expect_out(-500, 700, 900, 2000, 8'hA2);
      step;

      // reset while the divider is running
      wait_ready;
      offer(300, 300, 300, 3000, 8'hC0);
      step;
      i_valid = 1'b0;
      repeat (5) step;
      rstn = 1'b0;
      step;
      chk("abort_valid", 64'(o_valid), 64'd0);
      chk("abort_ready", 64'(i_ready), 64'd0);
      rstn = 1'b1;
      step;
      chk("abort_rel_ready", 64'(i_ready), 64'd1);
      chk("abort_rel_valid", 64'(o_valid), 64'd0);
      run_vertex(-3000, 1500, 2500, 6000, 8'hC1);

      for (int k = 0; k < 40; k++) begin
         if (k % 8 == 7) begin
            w = -longint'($urandom_range(500, 0));
            x = longint'($urandom_range(1000, 0)) - 500;
            y = longint'($urandom_range(1000, 0)) - 500;
            z = longint'($urandom_range(1000, 0)) - 500;
         end else begin
            w = longint'($urandom_range(1 << 20, 256));
            span = w + w / 4;
            x = longint'($urandom_range(32'(2 * span), 0)) - span;
            y = longint'($urandom_range(32'(2 * span), 0)) - span;
            z = longint'($urandom_range(32'(w + w / 4), 0)) - w / 8;
         end
         run_vertex(x, y, z, w, 8'(k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
